// File: rtl/servo_pwm_gen_if.sv
// rtl/servo_pwm_gen_if.sv - control/status interface of the servo PWM generator
// Carries wdt_trip_o only when SERVO_PWM_WATCHDOG_EN is defined.
interface servo_pwm_gen_if;
   logic        tick_clk_i;
   logic        enable_i;
   logic [15:0] width_i;
   logic        load_i;
   logic        load_ack_o;
   logic        pwm_o;
   logic        period_start_o;
`ifdef SERVO_PWM_WATCHDOG_EN
   logic        wdt_trip_o;

   modport master (
      output tick_clk_i, enable_i, width_i, load_i,
      input  load_ack_o, pwm_o, period_start_o, wdt_trip_o
   );

   modport slave (
      input  tick_clk_i, enable_i, width_i, load_i,
      output load_ack_o, pwm_o, period_start_o, wdt_trip_o
   );
`else
   modport master (
      output tick_clk_i, enable_i, width_i, load_i,
      input  load_ack_o, pwm_o, period_start_o
   );

   modport slave (
      input  tick_clk_i, enable_i, width_i, load_i,
      output load_ack_o, pwm_o, period_start_o
   );
`endif
endinterface

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - single-channel servo/ESC PWM generator on a divided-clock tick
// Optional watchdog: define SERVO_PWM_WATCHDOG_EN (adds WDT_PERIODS and wdt_trip_o).
module servo_pwm_gen #(
   parameter int PERIOD_TICKS = 20000,
   parameter int MIN_PULSE    = 1000,
   parameter int MAX_PULSE    = 2000
`ifdef SERVO_PWM_WATCHDOG_EN
   ,
   parameter int WDT_PERIODS  = 50
`endif
) (
   input logic            clk_i,
   input logic            reset,
   servo_pwm_gen_if.slave bus
);

   localparam int              CW    = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
   localparam logic [CW-1:0]   LAST  = CW'(PERIOD_TICKS - 1);
   localparam logic [15:0]     MIN_W = 16'(MIN_PULSE);
   localparam logic [15:0]     MAX_W = 16'(MAX_PULSE);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] count, count_n;
   logic [15:0]   pending, pending_n;
   logic [15:0]   active, active_n;
   logic          pwm, pwm_n;
   logic          pstart, pstart_n;
   logic          ack;
   logic [2:0]    sync;
   logic          tick;
   logic          at_last;
   logic          boundary;
   logic          start;
   logic [15:0]   width_c;
   logic [15:0]   start_w;
   logic          mute_start;
   logic          mute_run;

   function automatic logic [15:0] clamp_w(input logic [15:0] w);
      if (w < MIN_W)
         return MIN_W;
      else if (w > MAX_W)
         return MAX_W;
      else
         return w;
   endfunction

   // sync[1:0] resynchronise the divided clock; sync[2] is the previous level for edge detect
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset)
         sync <= 3'b000;
      else
         sync <= {sync[1:0], bus.tick_clk_i};
   end

   assign tick     = sync[1] & ~sync[2];
   assign at_last  = (count == LAST);
   assign boundary = tick && (state == RUN) && at_last;
   assign start    = tick && bus.enable_i && ((state == IDLE) || at_last);
   assign width_c  = clamp_w(bus.width_i);
   // A load landing on the starting tick is used directly so it is not one period late
   assign start_w  = bus.load_i ? width_c : pending;

`ifdef SERVO_PWM_WATCHDOG_EN
   localparam int            WW      = $clog2(WDT_PERIODS + 1);
   localparam logic [WW-1:0] WDT_MAX = WW'(WDT_PERIODS);

   logic [WW-1:0] wdt_cnt, wdt_cnt_n;
   logic          trip, trip_n;
   logic          mute, mute_n;

   always_comb begin
      wdt_cnt_n = wdt_cnt;
      trip_n    = trip;
      if (bus.load_i) begin
         wdt_cnt_n = '0;
         trip_n    = 1'b0;
      end else if (boundary) begin
         if (wdt_cnt != WDT_MAX)
            wdt_cnt_n = wdt_cnt + WW'(1);
         if (wdt_cnt_n == WDT_MAX)
            trip_n = 1'b1;
      end
      // Muting is latched per period so a clearing load only takes effect from the next period
      mute_n = start ? trip_n : mute;
   end

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         wdt_cnt <= '0;
         trip    <= 1'b0;
         mute    <= 1'b0;
      end else begin
         wdt_cnt <= wdt_cnt_n;
         trip    <= trip_n;
         mute    <= mute_n;
      end
   end

   assign mute_start     = trip_n;
   assign mute_run       = mute;
   assign bus.wdt_trip_o = trip;
`else
   assign mute_start = 1'b0;
   assign mute_run   = 1'b0;
`endif

   always_comb begin
      state_n   = state;
      count_n   = count;
      active_n  = active;
      pwm_n     = pwm;
      pstart_n  = 1'b0;
      pending_n = bus.load_i ? width_c : pending;
      if (start) begin
         state_n  = RUN;
         count_n  = '0;
         active_n = start_w;
         pstart_n = 1'b1;
         pwm_n    = (start_w != 16'd0) && !mute_start;
      end else begin
         case (state)
            IDLE: begin
               pwm_n = 1'b0;
            end
            RUN: begin
               if (boundary) begin
                  state_n = IDLE;
                  count_n = '0;
                  pwm_n   = 1'b0;
               end else if (tick) begin
                  count_n = count + CW'(1);
                  pwm_n   = (16'(count_n) < active) && !mute_run;
               end
            end
            default: begin
               state_n = IDLE;
               pwm_n   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         count   <= '0;
         pending <= MIN_W;
         active  <= MIN_W;
         pwm     <= 1'b0;
         pstart  <= 1'b0;
         ack     <= 1'b0;
      end else begin
         count   <= count_n;
         pending <= pending_n;
         active  <= active_n;
         pwm     <= pwm_n;
         pstart  <= pstart_n;
         ack     <= bus.load_i;
      end
   end

   assign bus.pwm_o          = pwm;
   assign bus.period_start_o = pstart;
   assign bus.load_ack_o     = ack;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - self-checking bench for servo_pwm_gen
// Watchdog checks are built only when SERVO_PWM_WATCHDOG_EN is defined.
module tb_servo_pwm_gen;

   localparam int P    = 20;
   localparam int MINP = 2;
   localparam int MAXP = 15;
   localparam int WDT  = 3;
`ifdef SERVO_PWM_WATCHDOG_EN
   localparam bit WDT_ON = 1'b1;
`else
   localparam bit WDT_ON = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic reset = 1'b0;
   always #5 clk_i = ~clk_i;

   servo_pwm_gen_if bus ();

   servo_pwm_gen #(
      .PERIOD_TICKS(P),
      .MIN_PULSE   (MINP),
      .MAX_PULSE   (MAXP)
`ifdef SERVO_PWM_WATCHDOG_EN
      ,
      .WDT_PERIODS (WDT)
`endif
   ) dut (
      .clk_i(clk_i),
      .reset(reset),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: where we are inside the PWM period, in plain integers
   bit m_run;
   int m_pos;
   int m_active;
   int m_pending;
   int m_periods;
   bit m_trip;
   bit m_mute;
   bit exp_ps;
   logic s_pwm;
   logic s_ps;

   typedef struct {
      logic [15:0] width;
      int          high;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int clampw(input int w);
      if (w < MINP) return MINP;
      if (w > MAXP) return MAXP;
      return w;
   endfunction

   function automatic int exp_pwm();
      return (m_run && (m_pos < m_active) && !m_mute) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_run = 0; m_pos = 0; m_active = MINP; m_pending = MINP;
      m_periods = 0; m_trip = 0; m_mute = 0; exp_ps = 0;
   endtask

   task automatic model_load(input logic [15:0] w);
      m_pending = clampw(int'(w));
      if (WDT_ON) begin
         m_periods = 0;
         m_trip    = 0;
      end
   endtask

   task automatic model_tick(input bit en, input bit ld, input logic [15:0] w);
      bit at_end;
      bit begin_new;
      at_end    = m_run && (m_pos == P - 1);
      begin_new = en && (!m_run || at_end);
      if (ld) m_pending = clampw(int'(w));
      if (WDT_ON) begin
         if (ld) begin
            m_periods = 0;
            m_trip    = 0;
         end else if (at_end) begin
            m_periods++;
            if (m_periods >= WDT) m_trip = 1;
         end
      end
      exp_ps = begin_new;
      if (begin_new) begin
         m_run = 1; m_pos = 0; m_active = m_pending; m_mute = m_trip;
      end else if (at_end) begin
         m_run = 0; m_pos = 0;
      end else if (m_run) begin
         m_pos++;
      end
   endtask

   task automatic check_trip(input string name);
`ifdef SERVO_PWM_WATCHDOG_EN
      check(name, bus.wdt_trip_o, m_trip);
`else
      n_cmp = n_cmp + 0;
      if (name.len() == 0) $display("empty check name");
`endif
   endtask

   // One tick: rising edge, two sync cycles, acting edge, then low long enough to re-arm
   task automatic do_tick(input bit en, input bit ld, input logic [15:0] w);
      bus.enable_i   = en;
      bus.tick_clk_i = 1'b1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      bus.load_i  = ld;
      bus.width_i = w;
      @(posedge clk_i); #1;
      bus.load_i     = 1'b0;
      bus.tick_clk_i = 1'b0;
      model_tick(en, ld, w);
      s_pwm = bus.pwm_o;
      s_ps  = bus.period_start_o;
      check("pwm", bus.pwm_o, exp_pwm());
      check("period_start", bus.period_start_o, exp_ps);
      check("load_ack", bus.load_ack_o, ld);
      check_trip("wdt_trip");
      @(posedge clk_i); #1;
      check("period_start_one_cycle", bus.period_start_o, 0);
      @(posedge clk_i); #1;
   endtask

   task automatic do_load(input logic [15:0] w);
      bus.load_i  = 1'b1;
      bus.width_i = w;
      @(posedge clk_i); #1;
      bus.load_i = 1'b0;
      model_load(w);
      check("load_ack", bus.load_ack_o, 1);
      check_trip("wdt_trip_after_load");
      @(posedge clk_i); #1;
      check("load_ack_one_cycle", bus.load_ack_o, 0);
   endtask

   task automatic run_window(input int en_ticks, input int ld_idx, input logic [15:0] ld_w,
                             output int high, output int starts);
      high   = 0;
      starts = 0;
      for (int i = 0; i < P; i++) begin
         do_tick(i < en_ticks, i == ld_idx, ld_w);
         high   += (s_pwm === 1'b1) ? 1 : 0;
         starts += (s_ps === 1'b1) ? 1 : 0;
      end
   endtask

   task automatic apply_reset();
      @(posedge clk_i); #2;
      reset = 1'b1;
      #1;
      check("reset_pwm", bus.pwm_o, 0);
      check("reset_load_ack", bus.load_ack_o, 0);
      check("reset_period_start", bus.period_start_o, 0);
`ifdef SERVO_PWM_WATCHDOG_EN
      check("reset_wdt_trip", bus.wdt_trip_o, 0);
`endif
      bus.tick_clk_i = 1'b0;
      bus.load_i     = 1'b0;
      @(posedge clk_i); #2;
      reset = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_i);
      #1;
   endtask

   vec_t vecs[9];
   int   high;
   int   starts;

   initial begin
      bus.tick_clk_i = 1'b0;
      bus.enable_i   = 1'b0;
      bus.width_i    = 16'd0;
      bus.load_i     = 1'b0;
      model_reset();

      vecs[0] = '{16'd5,     5};
      vecs[1] = '{16'd30,    15};
      vecs[2] = '{16'd0,     2};
      vecs[3] = '{16'd2,     2};
      vecs[4] = '{16'd15,    15};
      vecs[5] = '{16'd16,    15};
      vecs[6] = '{16'd1,     2};
      vecs[7] = '{16'hFFFF,  15};
      vecs[8] = '{16'd9,     9};

      apply_reset();

      // Reset mid-RUN while the pulse is high
      do_load(16'd5);
      do_tick(1'b1, 1'b0, 16'd0);
      do_tick(1'b1, 1'b0, 16'd0);
      check("t1_pwm_high_before_reset", bus.pwm_o, 1);
      apply_reset();
      do_tick(1'b0, 1'b0, 16'd0);
      check("t1_idle_no_start", s_ps, 0);
      do_tick(1'b1, 1'b0, 16'd0);
      check("t1_restart", s_ps, 1);

      // Clamp table, one full period per entry
      apply_reset();
      foreach (vecs[k]) begin
         do_load(vecs[k].width);
         run_window(P, -1, 16'd0, high, starts);
         check($sformatf("vec%0d_high_ticks", k), high, vecs[k].high);
         check($sformatf("vec%0d_starts", k), starts, 1);
      end

      // Mid-period load waits; boundary load takes effect at once
      apply_reset();
      do_load(16'd5);
      run_window(P, 10, 16'd8, high, starts);
      check("t4_current_period", high, 5);
      run_window(P, -1, 16'd0, high, starts);
      check("t4_next_period", high, 8);
      run_window(P, 0, 16'd11, high, starts);
      check("t4_boundary_bypass", high, 11);

      // Enable drop completes the running period
      apply_reset();
      do_load(16'd5);
      run_window(3, -1, 16'd0, high, starts);
      check("t5_last_period_high", high, 5);
      check("t5_last_period_start", starts, 1);
      run_window(0, -1, 16'd0, high, starts);
      check("t5_idle_high", high, 0);
      check("t5_idle_starts", starts, 0);

      // Stuck timebase: level held high or low produces no further ticks
      apply_reset();
      do_load(16'd7);
      do_tick(1'b1, 1'b0, 16'd0);
      do_tick(1'b1, 1'b0, 16'd0);
      repeat (30) @(posedge clk_i);
      #1;
      check("stuck_low_hold", bus.pwm_o, exp_pwm());
      bus.tick_clk_i = 1'b1;
      repeat (30) @(posedge clk_i);
      #1;
      model_tick(1'b1, 1'b0, 16'd0);
      check("stuck_high_single_tick", bus.pwm_o, exp_pwm());
      bus.tick_clk_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      do_tick(1'b1, 1'b0, 16'd0);

`ifdef SERVO_PWM_WATCHDOG_EN
      apply_reset();
      for (int w = 0; w < 3; w++) begin
         run_window(P, -1, 16'd0, high, starts);
         check($sformatf("t6_pre_trip_high%0d", w), high, MINP);
      end
      run_window(P, -1, 16'd0, high, starts);
      check("t6_tripped_high", high, 0);
      check("t6_trip_flag", bus.wdt_trip_o, 1);
      do_load(16'd6);
      check("t6_trip_cleared", bus.wdt_trip_o, 0);
      run_window(P, -1, 16'd0, high, starts);
      check("t6_recovered_high", high, 6);
`endif

      // Randomised traffic against the model
      apply_reset();
      for (int it = 0; it < 250; it++) begin
         bit          en;
         bit          ld;
         logic [15:0] w;
         en = ($urandom_range(0, 9) < 9);
         ld = ($urandom_range(0, 6) == 0);
         w  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 25)) : 16'($urandom);
         if ($urandom_range(0, 9) == 0)
            do_load(16'($urandom_range(0, 25)));
         do_tick(en, ld, w);
         repeat ($urandom_range(0, 3)) @(posedge clk_i);
         #1;
         check("rand_pwm_hold", bus.pwm_o, exp_pwm());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
